// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix scroller front end: FSM encoding,
// ASCII codes of the supported character set and the glyph index layout.
package matrix_pkg;

  localparam int unsigned GLYPH_W_DEF = 5;
  localparam int unsigned ROW_BITS    = 8;
  localparam int unsigned GLYPH_IDX_W = 6;
  localparam int unsigned COL_IDX_W   = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGlyph = 2'd1,
    StGap   = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_BANG  = 8'h21;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  localparam logic [7:0] ASCII_UZ    = 8'h5A;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LZ    = 8'h7A;
  localparam logic [7:0] ASCII_CASE  = 8'h20;

  // Glyph index layout: blank, digits 0-9, letters A-Z, then punctuation.
  localparam logic [GLYPH_IDX_W-1:0] GLYPH_BLANK   = 6'd0;
  localparam logic [GLYPH_IDX_W-1:0] GLYPH_DIGIT0  = 6'd1;
  localparam logic [GLYPH_IDX_W-1:0] GLYPH_ALPHA_A = 6'd11;
  localparam logic [GLYPH_IDX_W-1:0] GLYPH_BANG    = 6'd37;
  localparam logic [GLYPH_IDX_W-1:0] GLYPH_DOT     = 6'd38;
  localparam logic [GLYPH_IDX_W-1:0] GLYPH_DASH    = 6'd39;

endpackage

// File: rtl/font_rom_5x7.sv
// Combinational 5x7 font: ASCII-to-glyph-index map plus (glyph, column) lookup.
// Column bytes are LSB = top row; bit 7 is always 0.
module font_rom_5x7
  import matrix_pkg::*;
(
  input  logic [7:0]             i_ascii,
  output logic [GLYPH_IDX_W-1:0] o_glyph,
  input  logic [GLYPH_IDX_W-1:0] i_glyph,
  input  logic [COL_IDX_W-1:0]   i_col,
  output logic [ROW_BITS-1:0]    o_col
);

  logic [7:0]  w_upper;
  logic [39:0] w_bits;
  logic [7:0]  w_sel;

  assign w_upper = (i_ascii >= ASCII_LA && i_ascii <= ASCII_LZ) ? (i_ascii - ASCII_CASE) : i_ascii;

  always_comb begin
    o_glyph = GLYPH_BLANK;
    if (w_upper >= ASCII_0 && w_upper <= ASCII_9) begin
      o_glyph = GLYPH_DIGIT0 + GLYPH_IDX_W'(w_upper - ASCII_0);
    end else if (w_upper >= ASCII_UA && w_upper <= ASCII_UZ) begin
      o_glyph = GLYPH_ALPHA_A + GLYPH_IDX_W'(w_upper - ASCII_UA);
    end else begin
      case (w_upper)
        ASCII_SPACE: o_glyph = GLYPH_BLANK;
        ASCII_BANG:  o_glyph = GLYPH_BANG;
        ASCII_DOT:   o_glyph = GLYPH_DOT;
        ASCII_DASH:  o_glyph = GLYPH_DASH;
        default:     o_glyph = GLYPH_BLANK;
      endcase
    end
  end

  // Leftmost column sits in the most significant byte of each entry.
  always_comb begin
    w_bits = 40'h0;
    case (i_glyph)
      6'd1:  w_bits = 40'h3E5149453E;
      6'd2:  w_bits = 40'h00427F4000;
      6'd3:  w_bits = 40'h4261514946;
      6'd4:  w_bits = 40'h2141454B31;
      6'd5:  w_bits = 40'h1814127F10;
      6'd6:  w_bits = 40'h2745454539;
      6'd7:  w_bits = 40'h3C4A494930;
      6'd8:  w_bits = 40'h0171090503;
      6'd9:  w_bits = 40'h3649494936;
      6'd10: w_bits = 40'h064949291E;
      6'd11: w_bits = 40'h7E1111117E;
      6'd12: w_bits = 40'h7F49494936;
      6'd13: w_bits = 40'h3E41414122;
      6'd14: w_bits = 40'h7F4141221C;
      6'd15: w_bits = 40'h7F49494941;
      6'd16: w_bits = 40'h7F09090901;
      6'd17: w_bits = 40'h3E4149497A;
      6'd18: w_bits = 40'h7F0808087F;
      6'd19: w_bits = 40'h00417F4100;
      6'd20: w_bits = 40'h2040413F01;
      6'd21: w_bits = 40'h7F08142241;
      6'd22: w_bits = 40'h7F40404040;
      6'd23: w_bits = 40'h7F020C027F;
      6'd24: w_bits = 40'h7F0408107F;
      6'd25: w_bits = 40'h3E4141413E;
      6'd26: w_bits = 40'h7F09090906;
      6'd27: w_bits = 40'h3E4151215E;
      6'd28: w_bits = 40'h7F09192946;
      6'd29: w_bits = 40'h4649494931;
      6'd30: w_bits = 40'h01017F0101;
      6'd31: w_bits = 40'h3F4040403F;
      6'd32: w_bits = 40'h1F2040201F;
      6'd33: w_bits = 40'h3F4038403F;
      6'd34: w_bits = 40'h6314081463;
      6'd35: w_bits = 40'h0708700807;
      6'd36: w_bits = 40'h6151494543;
      6'd37: w_bits = 40'h00005F0000;
      6'd38: w_bits = 40'h0060600000;
      6'd39: w_bits = 40'h0808080808;
      default: w_bits = 40'h0;
    endcase
  end

  always_comb begin
    w_sel = 8'h00;
    case (i_col)
      3'd0:    w_sel = w_bits[39:32];
      3'd1:    w_sel = w_bits[31:24];
      3'd2:    w_sel = w_bits[23:16];
      3'd3:    w_sel = w_bits[15:8];
      3'd4:    w_sel = w_bits[7:0];
      default: w_sel = 8'h00;
    endcase
  end

  assign o_col = {1'b0, w_sel[6:0]};

endmodule

// File: rtl/char_column_feeder.sv
// Character FIFO feeding a font-expanding FSM; streams 8-bit glyph columns with a
// registered valid/ready output toward the matrix scroller.
module char_column_feeder
  import matrix_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned GLYPH_W    = GLYPH_W_DEF,
  parameter int unsigned GAP_COLS   = 1,
  parameter int unsigned IDLE_BLANK = 1
) (
  input  logic                          in_clk,
  input  logic                          rst,
  input  logic [7:0]                    in_char,
  input  logic                          in_char_valid,
  output logic                          ou_char_ready,
  output logic [ROW_BITS-1:0]           ou_col,
  output logic                          ou_col_valid,
  input  logic                          in_col_ready,
  output logic                          ou_busy,
  output logic [$clog2(FIFO_DEPTH):0]   ou_fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [COL_IDX_W-1:0] LAST_COL = COL_IDX_W'(GLYPH_W - 1);
  localparam logic [1:0] LAST_GAP = (GAP_COLS == 0) ? 2'd0 : 2'(GAP_COLS - 1);

  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_count;
  state_e                 r_state, w_state_d;
  logic [GLYPH_IDX_W-1:0] r_glyph, w_glyph_d;
  logic [COL_IDX_W-1:0]   r_col_idx, w_col_idx_d;
  logic [1:0]             r_gap_cnt, w_gap_cnt_d;
  logic [ROW_BITS-1:0]    r_col, w_col_d;
  logic                   r_col_valid, w_col_valid_d;

  logic                   w_push, w_pop, w_fifo_empty, w_slot_free;
  logic [GLYPH_IDX_W-1:0] w_head_glyph;
  logic [ROW_BITS-1:0]    w_rom_col;

  assign ou_char_ready = (r_count < DEPTH_C) && rst;
  assign w_push        = in_char_valid && ou_char_ready;
  assign w_fifo_empty  = (r_count == '0);
  assign w_slot_free   = !r_col_valid || in_col_ready;

  font_rom_5x7 u_font (
    .i_ascii (r_mem[r_rd_ptr]),
    .o_glyph (w_head_glyph),
    .i_glyph (r_glyph),
    .i_col   (r_col_idx),
    .o_col   (w_rom_col)
  );

  always_ff @(posedge in_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_char;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // The output register is only reloaded when the slot is free, so a stalled column
  // (glyph or idle blank) holds until the scroller takes it.
  always_comb begin
    w_state_d     = r_state;
    w_glyph_d     = r_glyph;
    w_col_idx_d   = r_col_idx;
    w_gap_cnt_d   = r_gap_cnt;
    w_col_d       = r_col;
    w_col_valid_d = r_col_valid;
    w_pop         = 1'b0;
    if (w_slot_free) begin
      unique case (r_state)
        StIdle: begin
          w_col_d = '0;
          if (!w_fifo_empty) begin
            w_pop         = 1'b1;
            w_glyph_d     = w_head_glyph;
            w_col_idx_d   = '0;
            w_state_d     = StGlyph;
            w_col_valid_d = 1'b0;
          end else begin
            w_col_valid_d = (IDLE_BLANK != 0);
          end
        end
        StGlyph: begin
          w_col_d       = w_rom_col;
          w_col_valid_d = 1'b1;
          w_col_idx_d   = r_col_idx + COL_IDX_W'(1);
          if (r_col_idx == LAST_COL) begin
            if (GAP_COLS != 0) begin
              w_state_d   = StGap;
              w_gap_cnt_d = '0;
            end else if (!w_fifo_empty) begin
              w_pop       = 1'b1;
              w_glyph_d   = w_head_glyph;
              w_col_idx_d = '0;
            end else begin
              w_state_d = StIdle;
            end
          end
        end
        StGap: begin
          w_col_d       = '0;
          w_col_valid_d = 1'b1;
          w_gap_cnt_d   = r_gap_cnt + 2'd1;
          if (r_gap_cnt == LAST_GAP) begin
            if (!w_fifo_empty) begin
              // Next character starts while the last gap column loads: no bubble.
              w_pop       = 1'b1;
              w_glyph_d   = w_head_glyph;
              w_col_idx_d = '0;
              w_state_d   = StGlyph;
            end else begin
              w_state_d = StIdle;
            end
          end
        end
        default: begin
          w_state_d     = StIdle;
          w_col_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_glyph     <= GLYPH_BLANK;
      r_col_idx   <= '0;
      r_gap_cnt   <= '0;
      r_col       <= '0;
      r_col_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_glyph     <= w_glyph_d;
      r_col_idx   <= w_col_idx_d;
      r_gap_cnt   <= w_gap_cnt_d;
      r_col       <= w_col_d;
      r_col_valid <= w_col_valid_d;
    end
  end

  assign ou_col        = r_col;
  assign ou_col_valid  = r_col_valid;
  assign ou_busy       = (r_count != '0) || (r_state != StIdle);
  assign ou_fifo_count = r_count;

endmodule

// File: tb/tb_char_column_feeder.sv
// Directed bench: one feeder without idle blanks (a_*) and one with idle blanks (b_*).
module tb_char_column_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_char, b_char;
  logic       a_char_valid, b_char_valid;
  logic       a_char_ready, b_char_ready;
  logic [7:0] a_col, b_col;
  logic       a_col_valid, b_col_valid;
  logic       a_col_ready, b_col_ready;
  logic       a_busy, b_busy;
  logic [4:0] a_count, b_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  char_column_feeder #(
    .FIFO_DEPTH (16),
    .GLYPH_W    (5),
    .GAP_COLS   (1),
    .IDLE_BLANK (0)
  ) u_dut (
    .in_clk        (clk),
    .rst           (rst),
    .in_char       (a_char),
    .in_char_valid (a_char_valid),
    .ou_char_ready (a_char_ready),
    .ou_col        (a_col),
    .ou_col_valid  (a_col_valid),
    .in_col_ready  (a_col_ready),
    .ou_busy       (a_busy),
    .ou_fifo_count (a_count)
  );

  char_column_feeder #(
    .FIFO_DEPTH (16),
    .GLYPH_W    (5),
    .GAP_COLS   (1),
    .IDLE_BLANK (1)
  ) u_dut_ib (
    .in_clk        (clk),
    .rst           (rst),
    .in_char       (b_char),
    .in_char_valid (b_char_valid),
    .ou_char_ready (b_char_ready),
    .ou_col        (b_col),
    .ou_col_valid  (b_col_valid),
    .in_col_ready  (b_col_ready),
    .ou_busy       (b_busy),
    .ou_fifo_count (b_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_a   [6]  = '{8'h7E, 8'h11, 8'h11, 8'h11, 8'h7E, 8'h00};
  logic [7:0] exp_bp  [12] = '{8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00,
                               8'h00, 8'h41, 8'h7F, 8'h41, 8'h00, 8'h00};
  logic [7:0] exp_ib  [6]  = '{8'h00, 8'h00, 8'h42, 8'h7F, 8'h40, 8'h00};
  logic       pat     [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int n_acc;
    rst = 1'b0;
    a_char = 8'h00; a_char_valid = 1'b0; a_col_ready = 1'b0;
    b_char = 8'h00; b_char_valid = 1'b0; b_col_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(a_col_valid), 32'd0);
    check("rst_col", 32'(a_col), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_ready", 32'(a_char_ready), 32'd0);
    check("rst_ib_valid", 32'(b_col_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("rel_ready", 32'(a_char_ready), 32'd1);

    // Basic flow: 'A' appears two edges after the push, six back-to-back columns
    a_col_ready = 1'b1;
    a_char = 8'h41; a_char_valid = 1'b1;
    tick();
    a_char_valid = 1'b0;
    check("basic_count1", 32'(a_count), 32'd1);
    check("basic_lat0", 32'(a_col_valid), 32'd0);
    tick();
    check("basic_lat1", 32'(a_col_valid), 32'd0);
    check("basic_busy", 32'(a_busy), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("basic_valid", 32'(a_col_valid), 32'd1);
      check("basic_col", 32'(a_col), 32'(exp_a[k]));
    end
    check("basic_busy_end", 32'(a_busy), 32'd0);
    tick();
    check("basic_idle_valid", 32'(a_col_valid), 32'd0);

    // Backpressure: "1I" with ready pattern 1,0,0,1 repeating
    a_col_ready = 1'b0;
    a_char = 8'h31; a_char_valid = 1'b1;
    tick();
    a_char = 8'h49;
    tick();
    a_char_valid = 1'b0;
    n_acc = 0;
    for (int cyc = 0; cyc < 80 && n_acc < 12; cyc++) begin
      a_col_ready = pat[cyc % 4];
      if (a_col_valid) begin
        check("bp_col", 32'(a_col), 32'(exp_bp[n_acc]));
        if (a_col_ready) n_acc++;
      end
      tick();
    end
    check("bp_accepted", 32'(n_acc), 32'd12);
    a_col_ready = 1'b1;
    tick();
    check("bp_no_extra", 32'(a_col_valid), 32'd0);
    check("bp_busy", 32'(a_busy), 32'd0);

    // Full FIFO: the first char is popped into the stalled output, 16 more fill it
    a_col_ready = 1'b0;
    tick();
    for (int i = 0; i < 17; i++) begin
      a_char = (i == 0) ? 8'h41 : 8'h30 + 8'(i % 10);
      a_char_valid = 1'b1;
      tick();
    end
    check("full_count", 32'(a_count), 32'd16);
    check("full_ready", 32'(a_char_ready), 32'd0);
    a_char = 8'h5A;
    tick();
    a_char_valid = 1'b0;
    check("full_reject", 32'(a_count), 32'd16);
    check("full_head_col", 32'(a_col), 32'h7E);
    a_col_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      check("full_drain_col", 32'(a_col), 32'(exp_a[k]));
      check("full_drain_cnt", 32'(a_count), 32'd16);
    end
    tick();
    check("full_gap_col", 32'(a_col), 32'h00);
    check("full_freed", 32'(a_count), 32'd15);
    a_col_ready = 1'b0;
    check("full_ready_again", 32'(a_char_ready), 32'd1);
    a_char = 8'h2E; a_char_valid = 1'b1;
    tick();
    a_char_valid = 1'b0;
    check("full_refill", 32'(a_count), 32'd16);
    a_col_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && a_busy; cyc++) tick();
    tick();
    check("full_drained_busy", 32'(a_busy), 32'd0);
    check("full_drained_cnt", 32'(a_count), 32'd0);

    // Mapping: 'a' -> 'A', '~' and ' ' -> blank glyphs, stream is gap-free
    a_char = 8'h61; a_char_valid = 1'b1;
    tick();
    a_char = 8'h7E;
    tick();
    a_char = 8'h20;
    tick();
    a_char_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      check("map_valid", 32'(a_col_valid), 32'd1);
      check("map_col", 32'(a_col), (k < 6) ? 32'(exp_a[k]) : 32'd0);
      tick();
    end
    check("map_busy", 32'(a_busy), 32'd0);
    tick();

    // Reset mid-glyph with three characters queued
    for (int i = 0; i < 4; i++) begin
      a_char = 8'h41; a_char_valid = 1'b1;
      tick();
    end
    a_char_valid = 1'b0;
    check("mid_col2", 32'(a_col), 32'h11);
    check("mid_queued", 32'(a_count), 32'd3);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(a_char_ready), 32'd0);
    tick();
    check("mid_rst_valid", 32'(a_col_valid), 32'd0);
    check("mid_rst_count", 32'(a_count), 32'd0);
    check("mid_rst_busy", 32'(a_busy), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("mid_no_stale", 32'(a_col_valid), 32'd0);
    end

    // Idle blank: continuous blanks, then a stalled blank delays a new character
    b_col_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("ib_blank_valid", 32'(b_col_valid), 32'd1);
      check("ib_blank_col", 32'(b_col), 32'd0);
      tick();
    end
    b_col_ready = 1'b0;
    b_char = 8'h31; b_char_valid = 1'b1;
    tick();
    b_char_valid = 1'b0;
    check("ib_stall_count", 32'(b_count), 32'd1);
    tick();
    check("ib_stall_hold", 32'(b_count), 32'd1);
    check("ib_stall_valid", 32'(b_col_valid), 32'd1);
    b_col_ready = 1'b1;
    n_acc = 0;
    for (int cyc = 0; cyc < 20 && n_acc < 6; cyc++) begin
      if (b_col_valid) begin
        check("ib_col", 32'(b_col), 32'(exp_ib[n_acc]));
        n_acc++;
      end
      tick();
    end
    check("ib_accepted", 32'(n_acc), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
